// File: rtl/aux_tick_scheduler_if.sv
// Config handshake bundle for aux_tick_scheduler: master drives a channel write
// and holds it until cfg_ready is seen high at a clock edge.
interface aux_tick_scheduler_if #(
    parameter int ChBit  = 2,
    parameter int PerBit = 16
) ();
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ChBit-1:0]  cfg_ch;
    logic [PerBit-1:0] cfg_period;
    logic              cfg_mode;
    logic              cfg_en;

    modport master (
        output cfg_valid, cfg_ch, cfg_period, cfg_mode, cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_period, cfg_mode, cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/aux_tick_scheduler.sv
// Shared-prescaler timer bank: NumCh one-shot/periodic channels pulse one cycle after an expiring base tick.
// Config lands on the next edge; cfg_ready drops only during the tick cycle so writes never race tick updates.
module aux_tick_scheduler #(
    parameter int PreMax = 100000,
    parameter int NumCh  = 4,
    parameter int ChBit  = 2,
    parameter int PerBit = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aux_tick_scheduler_if.slave  cfg,
    output logic                 tick_out,
    output logic [NumCh-1:0]     ch_pulse,
    output logic [NumCh-1:0]     ch_active
);
    localparam int PreW = $clog2(PreMax);
    localparam logic [PreW-1:0] PreLast = PreW'(PreMax - 1);

    logic [PreW-1:0]               pre_cnt_q, pre_cnt_d;
    logic [NumCh-1:0][PerBit-1:0]  rem_q, rem_d;
    logic [NumCh-1:0][PerBit-1:0]  per_q, per_d;
    logic [NumCh-1:0]              mode_q, mode_d;
    logic [NumCh-1:0]              active_q, active_d;
    logic [NumCh-1:0]              pulse_q, pulse_d;
    logic                          accept;

    assign tick_out      = (pre_cnt_q == PreLast);
    assign cfg.cfg_ready = !tick_out;
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign ch_pulse      = pulse_q;
    assign ch_active     = active_q;

    always_comb begin
        pre_cnt_d = (pre_cnt_q == PreLast) ? '0 : pre_cnt_q + 1'b1;
        rem_d     = rem_q;
        per_d     = per_q;
        mode_d    = mode_q;
        active_d  = active_q;
        pulse_d   = '0;
        for (int i = 0; i < NumCh; i++) begin
            // Tick and accept are mutually exclusive, so at most one branch fires per channel.
            if (tick_out && active_q[i]) begin
                if (rem_q[i] > PerBit'(1)) begin
                    rem_d[i] = rem_q[i] - 1'b1;
                end else begin
                    pulse_d[i] = 1'b1;
                    if (mode_q[i]) begin
                        rem_d[i] = per_q[i];
                    end else begin
                        active_d[i] = 1'b0;
                    end
                end
            end
            if (accept && (cfg.cfg_ch == ChBit'(i))) begin
                rem_d[i]    = cfg.cfg_period;
                per_d[i]    = cfg.cfg_period;
                mode_d[i]   = cfg.cfg_mode;
                active_d[i] = cfg.cfg_en && (cfg.cfg_period != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            rem_q     <= '0;
            per_q     <= '0;
            mode_q    <= '0;
            active_q  <= '0;
            pulse_q   <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            rem_q     <= rem_d;
            per_q     <= per_d;
            mode_q    <= mode_d;
            active_q  <= active_d;
            pulse_q   <= pulse_d;
        end
    end
endmodule
